// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between fetch (port 0) and LSU (port 1), tagging reads by owner.
// Define SRAM_ARB_RR_EN to use round-robin instead of fixed priority with a starvation guard.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  input  logic                    p1_we_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] p1_wmask_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    sram_csb_o,
  output logic                    sram_web_o,
  output logic [DATA_WIDTH/8-1:0] sram_wmask_o,
  output logic [ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [DATA_WIDTH-1:0]   sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);
  logic g0, g1, wr, rd;
  logic [READ_LAT-1:0] tag_v, tag_o;
`ifdef SRAM_ARB_RR_EN
  logic ptr;
  assign g0 = ~rst_i & p0_req_i & (~p1_req_i | ~ptr);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ptr <= 1'b0;
    else if (ptr ? g1 : g0) ptr <= ~ptr;
`else
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  logic [CW-1:0] starve;
  assign g0 = ~rst_i & p0_req_i & (~p1_req_i | (starve == SMAX));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) starve <= '0;
    else if (~p0_req_i | g0) starve <= '0;
    else if (starve != SMAX) starve <= starve + 1'b1;
`endif
  assign g1 = ~rst_i & p1_req_i & ~g0;
  assign wr = g1 & p1_we_i;
  assign rd = g0 | (g1 & ~p1_we_i);
  assign p0_gnt_o = g0;
  assign p1_gnt_o = g1;
  assign sram_csb_o = ~(g0 | g1);
  assign sram_web_o = ~wr;
  assign sram_addr_o = g0 ? p0_addr_i : (g1 ? p1_addr_i : '0);
  assign sram_wdata_o = wr ? p1_wdata_i : '0;
  assign sram_wmask_o = wr ? p1_wmask_i : '0;
  // Owner tag travels alongside the macro latency; bit 1 marks port 1.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= (tag_v << 1) | READ_LAT'(rd);
      tag_o <= (tag_o << 1) | READ_LAT'(g1);
    end
  assign p0_rvalid_o = tag_v[READ_LAT-1] & ~tag_o[READ_LAT-1];
  assign p1_rvalid_o = tag_v[READ_LAT-1] & tag_o[READ_LAT-1];
  assign p0_rdata_o = p0_rvalid_o ? sram_rdata_i : '0;
  assign p1_rdata_o = p1_rvalid_o ? sram_rdata_i : '0;
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port SRAM macro (active-low chip select and write enable, 16-bit word address, 32-bit data, 4-bit byte mask) between two requesters.
  - Port 0: instruction fetch, read-only.
  - Port 1: data load/store.
- Issues at most one SRAM command per cycle and tags each in-flight read with its owner.
- Routes read data back to the owning port after a fixed macro latency.
- Sits between the core's fetch and LSU units and the SRAM wrapper.

Parameters:
- ADDR_WIDTH, 16, word address width.
- DATA_WIDTH, 32, data width; the mask width is DATA_WIDTH/8.
- READ_LAT, 1, cycles from the command clock edge to valid sram_rdata_i; legal range 1..4.
- STARVE_MAX, 4, consecutive denied cycles of port 0 before it is force-granted.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- p0_req_i  in  1  port 0 read request.
- p0_addr_i  in  ADDR_WIDTH  port 0 address.
- p0_gnt_o  out  1  port 0 request accepted this cycle.
- p0_rvalid_o  out  1  port 0 read data valid.
- p0_rdata_o  out  DATA_WIDTH  port 0 read data.
- p1_req_i  in  1  port 1 request.
- p1_we_i  in  1  port 1 write (1 = write, 0 = read).
- p1_addr_i  in  ADDR_WIDTH  port 1 address.
- p1_wdata_i  in  DATA_WIDTH  port 1 write data.
- p1_wmask_i  in  DATA_WIDTH/8  port 1 byte mask.
- p1_gnt_o  out  1  port 1 request accepted this cycle.
- p1_rvalid_o  out  1  port 1 read data valid.
- p1_rdata_o  out  DATA_WIDTH  port 1 read data.
- sram_csb_o  out  1  SRAM chip select, active-low.
- sram_web_o  out  1  SRAM write enable, active-low.
- sram_wmask_o  out  DATA_WIDTH/8  SRAM byte mask.
- sram_addr_o  out  ADDR_WIDTH  SRAM address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset values, held while rst_i is high:
  - sram_csb_o=1, sram_web_o=1, sram_wmask_o=0, sram_addr_o=0, sram_wdata_o=0.
  - Both gnt=0, both rvalid=0, both rdata=0.
  - Tag pipe cleared, starvation counter=0, RR pointer=port 0.
- Handshake:
  - A request is held with its payload stable until gnt.
  - gnt is combinational in the same cycle.
  - The transfer completes at the clock edge where req&gnt=1.
  - At most one gnt per cycle.
- SRAM command: driven combinationally from the granted port in the same cycle.
  - csb=0, web=~we (port 0 always web=1).
  - Address, wdata and mask are passed through; for reads, wmask=0 and wdata=0.
  - With no grant: csb=1, web=1, and addr, wdata and mask are held at 0.
- Arbitration, default fixed priority:
  - Port 1 wins over port 0.
  - Starvation counter: +1 each cycle p0_req_i=1 and p0 is not granted; cleared on p0 grant or when p0_req_i=0.
  - When the counter equals STARVE_MAX, port 0 is granted that cycle even if p1_req_i=1.
  - The counter saturates at STARVE_MAX and never wraps.
- Read response:
  - Each granted read pushes {valid=1, owner} into a READ_LAT-deep shift pipe; each cycle without a granted read pushes valid=0.
  - When the pipe output is valid, the owner's rvalid=1 for exactly one cycle and its rdata=sram_rdata_i (combinational passthrough). The other port's rvalid=0.
  - Back-to-back reads give one response per cycle, in issue order.
  - No response backpressure: requesters always accept.
  - Writes produce no rvalid; the write is complete at grant.
- Port 0 write: port 0 never writes.
- Simultaneous events: a new grant and a pipe output in the same cycle are independent, with full throughput.
- Reset mid-operation: asynchronous assertion drops csb immediately and flushes the tag pipe. Reads in flight are discarded and their rvalid never fires.

Optional Feature:
- SRAM_ARB_RR_EN.
  - Defined: round-robin arbitration. The pointer toggles to the other port after each grant to the port it names. When both request, the pointer port wins; a lone requester is always granted. The starvation counter is removed.
  - Undefined: fixed priority with the starvation counter, as described in Behaviour.

Test Plan:
- Reset: hold rst_i 3 cycles with p0_req_i=1 and p1_req_i=1 -> sram_csb_o=1, sram_web_o=1, both gnt=0, both rvalid=0; first cycle after release p1_gnt_o=1.
- Single read: p0 reads addr 0x0010 while the SRAM holds 0xDEADBEEF there -> p0_gnt_o=1, sram_csb_o=0, sram_web_o=1; READ_LAT cycles later p0_rvalid_o=1 with p0_rdata_o=0xDEADBEEF and p1_rvalid_o=0.
- Masked write: p1 writes addr 0x0020, data 0x11223344, mask 4'b0101, then reads it back -> sram_web_o=0 and sram_wmask_o=0101 during the write; the readback returns the original bytes 3 and 1 with bytes 2 and 0 equal to 0x22 and 0x44.
- Contention, fixed priority: both ports request continuously for 12 cycles with STARVE_MAX=4 -> p1 granted 4 cycles, p0 granted on the 5th, and the pattern repeats.
- Interleaved reads: back-to-back reads p0@A, p1@B, p0@C with READ_LAT=2 -> rvalid sequence p0, p1, p0 on consecutive cycles with the correct data.
- Reset mid-read: assert rst_i one cycle after a read grant -> no rvalid on either port after reset is released.
